instruction_cache: RTL and testbench

//  Direct-mapped, read-only instruction cache between the CPU fetch port (PC/INSTRUCTION) and
//  the 128-bit-wide instruction memory. A hit returns the addressed word in the same cycle.
//  A miss asserts BUSYWAIT, which stalls PC update in the CPU. The cache then fetches the full
//  16-byte block, refills the line and releases the stall.

---
 rtl/instruction_cache_if.sv | 33 +++
 rtl/instruction_cache.sv | 110 +++++++++++
 tb/tb_instruction_cache.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/instruction_cache_if.sv
// Fetch-side and memory-side signals of the instruction cache, bundled as one interface.
// The slave modport is the cache; the master modport is the CPU/memory environment.
interface instruction_cache_if #(
    parameter int ADDR_W = 10
);
    logic [ADDR_W-1:0] address;
    logic [31:0]       instruction;
    logic              busywait;
    logic [ADDR_W-5:0] mem_address;
    logic              mem_read;
    logic [127:0]      mem_readdata;
    logic              mem_busywait;

    modport slave (
        input  address,
        output instruction,
        output busywait,
        output mem_address,
        output mem_read,
        input  mem_readdata,
        input  mem_busywait
    );

    modport master (
        output address,
        input  instruction,
        input  busywait,
        input  mem_address,
        input  mem_read,
        output mem_readdata,
        output mem_busywait
    );
endinterface

// File: rtl/instruction_cache.sv
// Direct-mapped read-only instruction cache: combinational hit path, and a
// three-state refill engine that fetches a 16-byte block on a miss.
module instruction_cache #(
    parameter int ADDR_W  = 10,
    parameter int INDEX_W = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    instruction_cache_if.slave bus_io
);
    localparam int TAG_W     = ADDR_W - INDEX_W - 4;
    localparam int NUM_LINES = 2 ** INDEX_W;

    typedef enum logic [1:0] {IDLE, FETCH, UPDATE} state_t;

    state_t               state_q, state_d;
    logic [TAG_W-1:0]     tag_q, tag_d;
    logic [INDEX_W-1:0]   index_q, index_d;
    logic [NUM_LINES-1:0] valid_q;
    logic [127:0]         block_q;
    logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
    logic [127:0]         data_mem [NUM_LINES];

    logic [TAG_W-1:0]     addr_tag;
    logic [INDEX_W-1:0]   addr_index;
    logic [1:0]           addr_word;
    logic                 hit;
    logic [31:0]          hit_word;
    logic                 capture;
    logic                 refill;
    logic                 busy;
    logic                 mem_read;
    logic [ADDR_W-5:0]    mem_address;

    assign addr_tag   = bus_io.address[ADDR_W-1:INDEX_W+4];
    assign addr_index = bus_io.address[INDEX_W+3:4];
    assign addr_word  = bus_io.address[3:2];

    assign hit      = valid_q[addr_index] && (tag_mem[addr_index] == addr_tag);
    assign hit_word = data_mem[addr_index][{addr_word, 5'd0} +: 32];

    always_comb begin
        state_d     = state_q;
        tag_d       = tag_q;
        index_d     = index_q;
        capture     = 1'b0;
        refill      = 1'b0;
        busy        = 1'b0;
        mem_read    = 1'b0;
        mem_address = '0;
        case (state_q)
            IDLE: begin
                busy = ~hit;
                if (!hit) begin
                    tag_d   = addr_tag;
                    index_d = addr_index;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                busy        = 1'b1;
                mem_read    = 1'b1;
                mem_address = {tag_q, index_q};
                if (!bus_io.mem_busywait) begin
                    capture = 1'b1;
                    state_d = UPDATE;
                end
            end
            UPDATE: begin
                busy    = 1'b1;
                refill  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            tag_q   <= '0;
            index_q <= '0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            tag_q   <= tag_d;
            index_q <= index_d;
            if (refill) begin
                valid_q[index_q] <= 1'b1;
            end
        end
    end

    // Line write uses the latched index only, so the fetch address is irrelevant in UPDATE.
    always_ff @(posedge clk) begin
        if (capture) begin
            block_q <= bus_io.mem_readdata;
        end
        if (refill) begin
            data_mem[index_q] <= block_q;
            tag_mem[index_q]  <= tag_q;
        end
    end

    // Reset must silence the stall and word outputs immediately, not at the next edge.
    assign bus_io.busywait    = rst_n && busy;
    assign bus_io.instruction = (rst_n && hit) ? hit_word : 32'h0;
    assign bus_io.mem_read    = mem_read;
    assign bus_io.mem_address = mem_address;
endmodule

// File: tb/tb_instruction_cache.sv
// Self-checking bench: directed scenarios plus random fetches, checked against a
// line-level valid/tag model and a backing store of 64 random blocks.
module tb_instruction_cache;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    instruction_cache_if #(.ADDR_W(10)) bus ();

    instruction_cache dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_io (bus)
    );

    logic [127:0] mem_blocks [64];
    int           mem_lat  = 0;
    int           busy_cnt = 0;
    int           checks   = 0;
    int           errors   = 0;
    bit           ref_valid [8];
    logic [2:0]   ref_tag   [8];

    // Memory: busy for mem_lat cycles of an ongoing read, then presents the block.
    assign bus.mem_busywait = bus.mem_read && (busy_cnt < mem_lat);
    assign bus.mem_readdata = mem_blocks[bus.mem_address];
    always @(posedge clk) busy_cnt <= bus.mem_read ? busy_cnt + 1 : 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] word_of(input logic [9:0] addr);
        logic [127:0] blk;
        blk = mem_blocks[addr[9:4]];
        return blk[addr[3:2]*32 +: 32];
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 8; i++) ref_valid[i] = 1'b0;
    endtask

    task automatic note_refill(input logic [9:0] addr);
        ref_valid[addr[6:4]] = 1'b1;
        ref_tag[addr[6:4]]   = addr[9:7];
    endtask

    // Observe one fetch whose address was applied in the current IDLE cycle.
    task automatic observe(input logic [9:0] addr, input int lat);
        bit exp_hit;
        int stall;
        int reads;
        @(negedge clk);
        exp_hit = ref_valid[addr[6:4]] && (ref_tag[addr[6:4]] == addr[9:7]);
        check("busy_first", bus.busywait, !exp_hit);
        check("read_idle", bus.mem_read, 1'b0);
        stall = 0;
        reads = 0;
        while (bus.busywait === 1'b1 && stall < 200) begin
            if (bus.mem_read === 1'b1) begin
                reads++;
                check("mem_addr", bus.mem_address, addr[9:4]);
            end
            stall++;
            @(negedge clk);
        end
        check("stall", 128'(stall), exp_hit ? 128'd0 : 128'(lat + 3));
        check("reads", 128'(reads), exp_hit ? 128'd0 : 128'(lat + 1));
        check("instr", bus.instruction, word_of(addr));
        check("read_done", bus.mem_read, 1'b0);
        note_refill(addr);
        $display("fetch addr=%03h lat=%0d hit=%0d stall=%0d instr=%08h",
                 addr, lat, exp_hit, stall, bus.instruction);
    endtask

    task automatic access(input logic [9:0] addr, input int lat);
        @(posedge clk);
        #1;
        bus.address = addr;
        mem_lat     = lat;
        observe(addr, lat);
    endtask

    int exp_busy [7] = '{1, 1, 1, 1, 1, 1, 0};
    int exp_read [7] = '{0, 1, 0, 0, 1, 0, 0};

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem_blocks[i] = {$urandom, $urandom, $urandom, $urandom};
        end
        mem_blocks[0] = {32'h0000_0004, 32'h0000_0003, 32'h0000_0002, 32'h0000_0001};
        clear_model();
        bus.address = 10'h000;
        mem_lat     = 5;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_busy", bus.busywait, 1'b0);
        check("rst_read", bus.mem_read, 1'b0);
        check("rst_maddr", bus.mem_address, 6'h00);
        check("rst_instr", bus.instruction, 32'h0);

        // Cold miss on 0x000 with 5 busy cycles
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        observe(10'h000, 5);
        check("cold_word", bus.instruction, 32'h0000_0001);

        // Same-block hits
        access(10'h004, 1);
        check("hit_w1", bus.instruction, 32'h0000_0002);
        access(10'h008, 1);
        check("hit_w2", bus.instruction, 32'h0000_0003);
        access(10'h00C, 1);
        check("hit_w3", bus.instruction, 32'h0000_0004);

        // Conflict on line 0
        access(10'h080, 3);
        access(10'h000, 2);

        // Address change during FETCH is ignored
        @(posedge clk);
        #1;
        bus.address = 10'h010;
        mem_lat     = 3;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("mid_busy", bus.busywait, 1'b1);
            if (c >= 1 && c <= 4) begin
                check("mid_read", bus.mem_read, 1'b1);
                check("mid_maddr", bus.mem_address, 6'h01);
            end
            if (c == 2) bus.address = 10'h3F0;
        end
        @(negedge clk);
        check("mid_remiss", bus.busywait, 1'b1);
        check("mid_idle", bus.mem_read, 1'b0);
        note_refill(10'h010);
        bus.address = 10'h010;
        #1;
        check("mid_hit", bus.busywait, 1'b0);
        check("mid_instr", bus.instruction, word_of(10'h010));
        $display("fetch addr=010 switched to 3F0 mid-fetch, line 1 refilled");
        access(10'h3F0, 2);

        // Reset two cycles into FETCH
        @(posedge clk);
        #1;
        bus.address = 10'h2A0;
        mem_lat     = 6;
        repeat (3) @(posedge clk);
        #1;
        check("pre_rst_read", bus.mem_read, 1'b1);
        rst_n = 1'b0;
        #1;
        check("arst_read", bus.mem_read, 1'b0);
        check("arst_busy", bus.busywait, 1'b0);
        check("arst_maddr", bus.mem_address, 6'h00);
        check("arst_instr", bus.instruction, 32'h0);
        clear_model();
        bus.address = 10'h000;
        mem_lat     = 2;
        $display("reset asserted mid-fetch of 2A0");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        observe(10'h000, 2);

        // Back-to-back misses with a 1-cycle memory
        rst_n = 1'b0;
        #1;
        clear_model();
        mem_lat = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            check("b2b_busy", bus.busywait, exp_busy[c] != 0);
            check("b2b_read", bus.mem_read, exp_read[c] != 0);
            if (c == 1) check("b2b_maddr0", bus.mem_address, 6'h00);
            if (c == 4) check("b2b_maddr1", bus.mem_address, 6'h01);
            if (c == 2) bus.address = 10'h010;
        end
        check("b2b_instr", bus.instruction, word_of(10'h010));
        note_refill(10'h000);
        note_refill(10'h010);
        $display("back-to-back misses 000 then 010 done");

        // Random fetches over 16 blocks sharing 8 lines
        for (int n = 0; n < 40; n++) begin
            logic [9:0] a;
            a = {1'b0, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
            access(a, int'($urandom_range(0, 4)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
